// File: rtl/matrix_uart_store_parser.sv
// ============================================================================
// matrix_uart_store_parser
// ----------------------------------------------------------------------------
// Receive-side parser for STORE mode. It turns an ASCII matrix arriving from
// UartRx ("m n e0 e1 ... e(m*n-1)") into the row-major matrixIO layout and
// commits it with a one-cycle write strobe.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   mode_active       high while STORE mode is selected; low aborts to IDLE
//   rx_data, rx_done  received byte and its one-cycle strobe
//   storage_we        one-cycle matrixIO write strobe
//   storage_dimX/Y    committed rows m / cols n
//   storage_wdata     element k = r*n+c in bits [8k+7:8k], unused bytes 0
//   done_pulse        one cycle, coincident with storage_we
//   err_pulse         one cycle per detected error
//   busy              high in GET_N / GET_ELEM / COMMIT
//
// Build option
//   STORE_ZERO_FILL_EN : an idle timeout inside the element list completes
//                        the pending token, zero-pads the rest and commits.
//                        Undefined, every timeout while busy is an error.
// ============================================================================
module matrix_uart_store_parser #(
    parameter int MAX_DIM        = 5,
    parameter int MAX_VAL        = 255,
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             mode_active,
    input  logic [7:0]                       rx_data,
    input  logic                             rx_done,
    output logic                             storage_we,
    output logic [7:0]                       storage_dimX,
    output logic [7:0]                       storage_dimY,
    output logic [8*MAX_DIM*MAX_DIM-1:0]     storage_wdata,
    output logic                             done_pulse,
    output logic                             err_pulse,
    output logic                             busy
);

    localparam int         NELEM = MAX_DIM * MAX_DIM;
    localparam int         WBITS = 8 * NELEM;
    localparam int         IDX_W = $clog2(NELEM + 1);
    localparam int         TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [8:0] MAXV  = 9'(MAX_VAL);
    localparam logic [8:0] MAXD  = 9'(MAX_DIM);

    typedef enum logic [2:0] {
        S_IDLE, S_GET_M, S_GET_N, S_GET_ELEM, S_COMMIT
    } state_e;

    state_e             state_q, state_d, parse_state;
    logic [8:0]         acc_q, acc_d;
    logic               pend_q, pend_d;
    logic [7:0]         m_q, m_d, n_q, n_d;
    logic [IDX_W-1:0]   idx_q, idx_d, idx_inc, total;
    logic [WBITS-1:0]   work_q, work_d;
    logic [7:0]         dimx_q, dimx_d, dimy_q, dimy_d;
    logic [WBITS-1:0]   wdata_q, wdata_d;
    logic               err_q, err_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;

    logic               is_digit, is_delim, ovf, dim_ok, timeout;
    logic               tok, fill, do_err, go_commit;
    logic [12:0]        acc_ext;

    assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign is_delim = (rx_data == 8'h20) || (rx_data == 8'h2C) ||
                      (rx_data == 8'h0D) || (rx_data == 8'h0A);
    assign acc_ext  = 13'(acc_q) * 13'd10 + 13'(rx_data) - 13'h30;
    assign ovf      = acc_q > MAXV;
    assign dim_ok   = (acc_q != 9'd0) && (acc_q <= MAXD);
    assign total    = m_q[IDX_W-1:0] * n_q[IDX_W-1:0];
    assign idx_inc  = idx_q + IDX_W'(1);

    assign busy    = (state_q == S_GET_N) || (state_q == S_GET_ELEM) ||
                     (state_q == S_COMMIT);
    assign timeout = busy && !rx_done && (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1));

    // Idle timer: only runs while busy and reloads on every received byte.
    assign tmr_d = (!busy || rx_done || timeout || !mode_active) ? '0 : tmr_q + TMR_W'(1);

    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        // COMMIT lasts one cycle; its bytes are parsed as if already in GET_M.
        parse_state = (state_q == S_COMMIT) ? S_GET_M : state_q;
        state_d     = parse_state;
        acc_d       = acc_q;
        pend_d      = pend_q;
        m_d         = m_q;
        n_d         = n_q;
        idx_d       = idx_q;
        work_d      = work_q;
        dimx_d      = dimx_q;
        dimy_d      = dimy_q;
        wdata_d     = wdata_q;
        err_d       = 1'b0;
        tok         = 1'b0;
        fill        = 1'b0;
        do_err      = 1'b0;
        go_commit   = 1'b0;

        if (!mode_active) begin
            // Abort silently: partial data dropped, no write, no error.
            state_d = S_IDLE;
            acc_d   = '0;
            pend_d  = 1'b0;
            idx_d   = '0;
        end else if (state_q == S_IDLE) begin
            state_d = S_GET_M;
            acc_d   = '0;
            pend_d  = 1'b0;
        end else begin
            if (rx_done) begin
                if (is_digit) begin
                    acc_d  = (acc_ext > 13'd511) ? 9'd511 : acc_ext[8:0];
                    pend_d = 1'b1;
                end else if (is_delim) begin
                    tok = pend_q;
                end else begin
                    do_err = 1'b1;
                end
            end else if (timeout) begin
`ifdef STORE_ZERO_FILL_EN
                if (state_q == S_GET_ELEM && (idx_q != '0 || pend_q)) begin
                    tok  = pend_q;
                    fill = 1'b1;
                end else begin
                    do_err = 1'b1;
                end
`else
                do_err = 1'b1;
`endif
            end

            if (tok) begin
                acc_d  = '0;
                pend_d = 1'b0;
                unique case (parse_state)
                    S_GET_M: begin
                        if (dim_ok) begin
                            m_d     = acc_q[7:0];
                            state_d = S_GET_N;
                        end else begin
                            do_err = 1'b1;
                        end
                    end
                    S_GET_N: begin
                        if (dim_ok) begin
                            n_d     = acc_q[7:0];
                            work_d  = '0;
                            idx_d   = '0;
                            state_d = S_GET_ELEM;
                        end else begin
                            do_err = 1'b1;
                        end
                    end
                    S_GET_ELEM: begin
                        if (!ovf) begin
                            work_d[idx_q*8 +: 8] = acc_q[7:0];
                            idx_d = idx_inc;
                            if (idx_inc == total) go_commit = 1'b1;
                        end else begin
                            do_err = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            // Zero-fill commit: untouched bytes of work are already zero.
            if (fill && !do_err) go_commit = 1'b1;

            if (do_err) begin
                err_d     = 1'b1;
                acc_d     = '0;
                pend_d    = 1'b0;
                idx_d     = '0;
                state_d   = S_GET_M;
                go_commit = 1'b0;
            end

            // Outputs are loaded together with the move to COMMIT so they are
            // already stable during the strobe cycle.
            if (go_commit) begin
                state_d = S_COMMIT;
                dimx_d  = m_q;
                dimy_d  = n_q;
                wdata_d = work_d;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            pend_q  <= 1'b0;
            m_q     <= 8'd1;
            n_q     <= 8'd1;
            idx_q   <= '0;
            dimx_q  <= 8'd1;
            dimy_q  <= 8'd1;
            wdata_q <= '0;
            err_q   <= 1'b0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            pend_q  <= pend_d;
            m_q     <= m_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            dimx_q  <= dimx_d;
            dimy_q  <= dimy_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            tmr_q   <= tmr_d;
        end
    end

    // NOTE: the working buffer needs no reset; it is cleared on every accepted
    // column count before any element is written.
    always_ff @(posedge clk) begin
        work_q <= work_d;
    end

    assign storage_we    = (state_q == S_COMMIT);
    assign done_pulse    = (state_q == S_COMMIT);
    assign storage_dimX  = dimx_q;
    assign storage_dimY  = dimy_q;
    assign storage_wdata = wdata_q;
    assign err_pulse     = err_q;

endmodule
